// File: rtl/xe4_int_ctrl.sv
// xe4_int_ctrl: interrupt controller for the XE4 CPU.
//   Each raw line goes through a 2-flop synchronizer and is then either edge-latched
//   or passed through as a level. The request is gated by a mask, a global enable
//   and the service state. The lowest-index eligible channel is presented to the CPU
//   as int_req, together with int_id and int_vec.
//   All state changes on the falling edge of clk, which is the edge the CPU uses.
// Optional feature: define XE4_INTC_NMI_EN to make channel 0 non-maskable.
//   Channel 0 is then always edge mode. It ignores mask, gie and in_service, and it
//   may nest one level deep into a running service.
// Ports:
//   clk, rst_n          falling-edge clock, async active-low reset
//   irq_in[NCH]         raw interrupt lines (asynchronous)
//   edge_mode[NCH]      1 = rising-edge latched, 0 = level-high
//   mask_we/mask_wdata  mask register load (1 = enabled)
//   gie_set/gie_clr     global enable set/clear pulses (clear wins)
//   int_ack/int_done    CPU accept / end-of-service pulses
//   int_req/int_id/int_vec  registered request, granted channel and handler address
//   pending[NCH]        current pending vector
//   in_service          a handler is active
module xe4_int_ctrl #(
  parameter int unsigned      NCH        = 4,
  parameter int unsigned      AW         = 15,
  parameter logic [AW-1:0]    VEC_BASE   = 15'h0004,
  parameter logic [AW-1:0]    VEC_STRIDE = 15'h0008
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  irq_in,
  input  logic [NCH-1:0]  edge_mode,
  input  logic            mask_we,
  input  logic [NCH-1:0]  mask_wdata,
  input  logic            gie_set,
  input  logic            gie_clr,
  input  logic            int_ack,
  input  logic            int_done,
  output logic            int_req,
  output logic [AW-1:0]   int_vec,
  output logic [2:0]      int_id,
  output logic [NCH-1:0]  pending,
  output logic            in_service
);

  localparam int unsigned IDW = 3;

  // S_NREQ / S_NSVC are reachable only with the NMI feature.
  // They are the request and the service of a nested level.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_SVC  = 3'd2,
    S_NREQ = 3'd3,
    S_NSVC = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [NCH-1:0]  sync1, sync2, sync2_d;
  logic [NCH-1:0]  pend, mask;
  logic            gie, req, isr;
  logic [IDW-1:0]  id;
  logic [AW-1:0]   vec;

  logic [NCH-1:0]  emode_c, rise_c, pend_nx_c, elig_c;
  logic            ack_c, grant_c, nmi_hold_c;
  logic [IDW-1:0]  win_id_c;
  logic [AW-1:0]   win_vec_c;
  logic            req_nx_c, isr_nx_c, gie_nx_c, load_c;

  // Synchronizer followed by a delayed copy for the rising-edge detector.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_d <= '0;
    end else begin
      sync1   <= irq_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

`ifdef XE4_INTC_NMI_EN
  assign emode_c    = edge_mode | NCH'(1);
  assign nmi_hold_c = (id == '0);
`else
  assign emode_c    = edge_mode;
  assign nmi_hold_c = 1'b0;
`endif

  assign rise_c = sync2 & ~sync2_d;
  assign ack_c  = int_ack & req;

  // Next pending value. An edge bit is cleared by the ack of its own channel.
  // A new edge in the same cycle keeps the bit set. A level bit follows the synchronized line.
  always_comb begin
    pend_nx_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (emode_c[i])
        pend_nx_c[i] = (pend[i] & ~(ack_c && (id == IDW'(i)))) | rise_c[i];
      else
        pend_nx_c[i] = sync2[i];
    end
  end

  // Eligibility and fixed-priority arbitration (lowest index wins).
  always_comb begin
    elig_c = '0;
    if (state == S_IDLE)
      elig_c = pend & mask & {NCH{gie}};
`ifdef XE4_INTC_NMI_EN
    elig_c[0] = pend[0] & ((state == S_IDLE) || (state == S_SVC));
`endif
    win_id_c = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (elig_c[i])
        win_id_c = IDW'(i);
    end
    grant_c   = |elig_c;
    win_vec_c = VEC_BASE + AW'(win_id_c) * VEC_STRIDE;
  end

  // State register.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic. A pending ack beats gie_clr. A non-maskable request is never withdrawn.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (grant_c) state_nx = S_REQ;
      S_REQ: begin
        if (int_ack)                    state_nx = S_SVC;
        else if (gie_clr && !nmi_hold_c) state_nx = S_IDLE;
      end
      S_SVC: begin
        if (int_done)     state_nx = S_IDLE;
        else if (grant_c) state_nx = S_NREQ;
      end
      S_NREQ: begin
        if (int_ack && int_done) state_nx = S_SVC;
        else if (int_ack)        state_nx = S_NSVC;
        else if (int_done)       state_nx = S_REQ;
      end
      S_NSVC: if (int_done) state_nx = S_SVC;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    req_nx_c = (state_nx == S_REQ) || (state_nx == S_NREQ);
    isr_nx_c = (state_nx == S_SVC) || (state_nx == S_NREQ) || (state_nx == S_NSVC);
    load_c   = grant_c && req_nx_c && !req;
    gie_nx_c = gie;
    if (ack_c || gie_clr)
      gie_nx_c = 1'b0;
    else if (gie_set)
      gie_nx_c = 1'b1;
  end

  // Registered outputs and control state.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      mask <= '0;
      gie  <= 1'b0;
      req  <= 1'b0;
      isr  <= 1'b0;
      id   <= '0;
      vec  <= '0;
    end else begin
      pend <= pend_nx_c;
      if (mask_we)
        mask <= mask_wdata;
      gie <= gie_nx_c;
      req <= req_nx_c;
      isr <= isr_nx_c;
      if (load_c) begin
        id  <= win_id_c;
        vec <= win_vec_c;
      end
    end
  end

  assign int_req    = req;
  assign int_id     = id;
  assign int_vec    = vec;
  assign pending    = pend;
  assign in_service = isr;

endmodule
